// File: rtl/dmem_access_unit_if.sv
// Bundle of the request/response handshake and the doubleword memory port of
// the data-memory access unit. The master side is the control unit plus the
// memory; the slave side is the access unit itself.
interface dmem_access_unit_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        store_splice;
  logic [1:0]        load_splice;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, store_splice, load_splice,
    output mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, store_splice, load_splice,
    input  mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns LD/LW/LH/LBU loads and SD/SW/SH/SB stores
// into accesses on a 64-bit doubleword memory port. Sub-word stores are done
// as read-modify-write, loads are lane-extracted and extended, misaligned
// accesses are rejected with an error response and never touch memory.
module dmem_access_unit (
  input  logic                clk,
  input  logic                reset,
  dmem_access_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    RD_WAIT = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  ssp_q, ssp_d;
  logic [1:0]  lsp_q, lsp_d;
  logic [63:0] rdata_q, rdata_d;

  // Size encoding shared by both splices: 00 = 8, 01 = 4, 10 = 2, 11 = 1 byte.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sel);
    logic bad;
    case (sel)
      2'b00:   bad = (off != 3'd0);
      2'b01:   bad = (off[1:0] != 2'd0);
      2'b10:   bad = off[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Pull the addressed little-endian lane down to bit 0 and extend it.
  function automatic logic [63:0] load_extend(input logic [2:0] off, input logic [1:0] sel,
                                              input logic [63:0] dw);
    logic        [63:0] shifted;
    logic signed [31:0] w;
    logic signed [15:0] h;
    logic signed [63:0] ext;
    shifted = dw >> {off, 3'b000};
    w       = shifted[31:0];
    h       = shifted[15:0];
    case (sel)
      2'b00:   ext = shifted;
      2'b01:   ext = w;
      2'b10:   ext = h;
      default: ext = {56'd0, shifted[7:0]};
    endcase
    return ext;
  endfunction

  // Replace only the addressed bytes of the old doubleword; for SD the mask
  // covers every lane so the old value drops out entirely.
  function automatic logic [63:0] store_merge(input logic [2:0] off, input logic [1:0] sel,
                                              input logic [63:0] old_dw, input logic [63:0] wd);
    logic [63:0] mask;
    logic [63:0] mask_sh;
    logic [63:0] data_sh;
    case (sel)
      2'b00:   mask = 64'hFFFF_FFFF_FFFF_FFFF;
      2'b01:   mask = 64'h0000_0000_FFFF_FFFF;
      2'b10:   mask = 64'h0000_0000_0000_FFFF;
      default: mask = 64'h0000_0000_0000_00FF;
    endcase
    mask_sh = mask << {off, 3'b000};
    data_sh = wd << {off, 3'b000};
    return (old_dw & ~mask_sh) | (data_sh & mask_sh);
  endfunction

  // State and captured request; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      ssp_q   <= 2'b00;
      lsp_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      ssp_q   <= ssp_d;
      lsp_q   <= lsp_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state sequencing and per-state strobes.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    write_d         = write_q;
    ssp_d           = ssp_q;
    lsp_d           = lsp_q;
    rdata_d         = rdata_q;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_err    = 1'b0;
    bus.resp_rdata  = '0;
    bus.mem_re      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_wdata   = '0;
    bus.mem_addr    = {addr_q[63:3], 3'b000};

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          ssp_d   = bus.store_splice;
          lsp_d   = bus.load_splice;
          if (misaligned(bus.req_addr[2:0],
                         bus.req_write ? bus.store_splice : bus.load_splice)) begin
            state_d = ERR;
          end else if (bus.req_write && bus.store_splice == 2'b00) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        bus.mem_re = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = bus.mem_rdata;
        state_d = write_q ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = store_merge(addr_q[2:0], ssp_q, rdata_q, wdata_q);
        state_d       = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = write_q ? 64'd0 : load_extend(addr_q[2:0], lsp_q, rdata_q);
        state_d        = IDLE;
      end
      ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a small doubleword memory model.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_access_unit_if bus ();

  dmem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: eight doublewords, read data one cycle after mem_re.
  logic        mem_init;
  logic [63:0] mem [8];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 64'd0;
      mem[2] <= 64'h8877665544332211;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[5:3]] <= bus.mem_wdata;
    end
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[5:3]];
    else            bus.mem_rdata <= {$urandom, $urandom};
  end

  // Strobe monitor, sampled mid-cycle.
  int          re_cnt = 0;
  int          we_cnt = 0;
  int          both_cnt = 0;
  logic [63:0] we_data = '0;
  logic [63:0] we_addr = '0;
  always @(negedge clk) begin
    if (bus.mem_re) re_cnt++;
    if (bus.mem_we) begin
      we_cnt++;
      we_data = bus.mem_wdata;
      we_addr = bus.mem_addr;
    end
    if (bus.mem_re && bus.mem_we) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'($urandom);
    bus.req_addr     = {$urandom, $urandom};
    bus.req_wdata    = {$urandom, $urandom};
    bus.store_splice = 2'($urandom);
    bus.load_splice  = 2'($urandom);
  endtask

  task automatic xact(input string name, input bit wr, input logic [63:0] addr,
                      input logic [63:0] wd, input logic [1:0] ssp, input logic [1:0] lsp,
                      input int exp_lat, input bit exp_err, input logic [63:0] exp_rd,
                      input int exp_re, input int exp_we, input logic [63:0] exp_wd);
    int re0, we0, n;
    @(negedge clk);
    chk({name, ".ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.store_splice = ssp;
    bus.load_splice  = lsp;
    @(posedge clk);
    #1;
    scramble_inputs();
    re0 = re_cnt;
    we0 = we_cnt;
    n = 1;
    while (!bus.resp_valid && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, ".latency"}, 64'(n), 64'(exp_lat));
    chk({name, ".err"}, 64'(bus.resp_err), 64'(exp_err));
    if (!wr || exp_err) chk({name, ".rdata"}, bus.resp_rdata, exp_rd);
    @(posedge clk);
    #1;
    chk({name, ".pulse"}, 64'(bus.resp_valid), 64'd0);
    chk({name, ".idle"}, 64'(bus.req_ready), 64'd1);
    chk({name, ".re_cnt"}, 64'(re_cnt - re0), 64'(exp_re));
    chk({name, ".we_cnt"}, 64'(we_cnt - we0), 64'(exp_we));
    chk({name, ".both"}, 64'(both_cnt), 64'd0);
    if (exp_we > 0) begin
      chk({name, ".wdata"}, we_data, exp_wd);
      chk({name, ".waddr"}, we_addr, {addr[63:3], 3'b000});
    end
  endtask

  initial begin
    int rv, we0;
    reset    = 1'b0;
    mem_init = 1'b1;
    scramble_inputs();
    bus.req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(bus.req_ready), 64'd1);
    chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst.resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst.mem_re", 64'(bus.mem_re), 64'd0);
    chk("rst.mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst.mem_addr", bus.mem_addr, 64'd0);
    chk("rst.mem_wdata", bus.mem_wdata, 64'd0);
    @(negedge clk);
    mem_init = 1'b0;
    bus.req_valid = 1'b0;
    reset = 1'b1;

    //   name     wr  addr    wdata                  ssp    lsp    lat err rdata                  re we wdata
    xact("ld10",  0, 64'h10, 64'h0,                 2'b01, 2'b00, 3, 0, 64'h8877665544332211, 1, 0, 64'h0);
    xact("lw14",  0, 64'h14, 64'h0,                 2'b11, 2'b01, 3, 0, 64'hFFFFFFFF88776655, 1, 0, 64'h0);
    xact("lbu17", 0, 64'h17, 64'h0,                 2'b00, 2'b11, 3, 0, 64'h0000000000000088, 1, 0, 64'h0);
    xact("lh12",  0, 64'h12, 64'h0,                 2'b00, 2'b10, 3, 0, 64'h0000000000004433, 1, 0, 64'h0);
    xact("lh14",  0, 64'h14, 64'h0,                 2'b00, 2'b10, 3, 0, 64'h0000000000006655, 1, 0, 64'h0);
    xact("sb11",  1, 64'h11, 64'hAB,                2'b11, 2'b01, 4, 0, 64'h0,                1, 1, 64'h887766554433AB11);
    xact("ld10b", 0, 64'h10, 64'h0,                 2'b10, 2'b00, 3, 0, 64'h887766554433AB11, 1, 0, 64'h0);
    xact("lh10",  0, 64'h10, 64'h0,                 2'b00, 2'b10, 3, 0, 64'hFFFFFFFFFFFFAB11, 1, 0, 64'h0);
    xact("sh13",  1, 64'h13, 64'h1234,              2'b10, 2'b11, 1, 1, 64'h0,                0, 0, 64'h0);
    xact("sd14",  1, 64'h14, 64'h1234,              2'b00, 2'b11, 1, 1, 64'h0,                0, 0, 64'h0);
    xact("ld13",  0, 64'h13, 64'h0,                 2'b11, 2'b00, 1, 1, 64'h0,                0, 0, 64'h0);
    xact("lw16",  0, 64'h16, 64'h0,                 2'b11, 2'b01, 1, 1, 64'h0,                0, 0, 64'h0);
    xact("sd18",  1, 64'h18, 64'h0123456789ABCDEF,  2'b00, 2'b01, 2, 0, 64'h0,                0, 1, 64'h0123456789ABCDEF);
    xact("ld18",  0, 64'h18, 64'h0,                 2'b01, 2'b00, 3, 0, 64'h0123456789ABCDEF, 1, 0, 64'h0);
    xact("sw1c",  1, 64'h1C, 64'hDEADBEEF,          2'b01, 2'b00, 4, 0, 64'h0,                1, 1, 64'hDEADBEEF89ABCDEF);
    xact("lh1e",  0, 64'h1E, 64'h0,                 2'b00, 2'b10, 3, 0, 64'hFFFFFFFFFFFFDEAD, 1, 0, 64'h0);
    xact("sb18",  1, 64'h18, 64'hFFFFFFFFFFFFFF5A,  2'b11, 2'b00, 4, 0, 64'h0,                1, 1, 64'hDEADBEEF89ABCD5A);
    xact("lbu1a", 0, 64'h1A, 64'h0,                 2'b00, 2'b11, 3, 0, 64'h00000000000000AB, 1, 0, 64'h0);
    xact("lw18",  0, 64'h18, 64'h0,                 2'b00, 2'b01, 3, 0, 64'hFFFFFFFF89ABCD5A, 1, 0, 64'h0);

    // Reset while a sub-word store sits in RD_WAIT.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_addr     = 64'h18;
    bus.req_wdata    = 64'h55;
    bus.store_splice = 2'b01;
    bus.load_splice  = 2'b00;
    @(posedge clk);
    #1;
    scramble_inputs();
    @(posedge clk);
    #1;
    we0 = we_cnt;
    reset = 1'b0;
    #1;
    chk("arst.ready", 64'(bus.req_ready), 64'd1);
    chk("arst.resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("arst.mem_re", 64'(bus.mem_re), 64'd0);
    chk("arst.mem_we", 64'(bus.mem_we), 64'd0);
    chk("arst.mem_addr", bus.mem_addr, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) rv++;
    end
    chk("arst.no_resp", 64'(rv), 64'd0);
    chk("arst.no_write", 64'(we_cnt - we0), 64'd0);
    chk("arst.ready_after", 64'(bus.req_ready), 64'd1);
    xact("ld18r", 0, 64'h18, 64'h0, 2'b00, 2'b00, 3, 0, 64'hDEADBEEF89ABCD5A, 1, 0, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
